rr_grant_scheduler: RTL and testbench
=====================================

Name: rr_grant_scheduler

Overview:
- Round-robin scheduler that shares one downstream resource (the 4-to-2 encoded datapath channel) among four requesters.
- Registers a one-hot grant plus its 2-bit binary encoding, using the same mapping as the team's 4-to-2 encoder.
- Holds the grant until the owner finishes, then rotates priority.
- Sits between the requesting blocks and the shared channel; the channel's select is driven by GNT_IDX.

Parameters:
- MAX_HOLD, 16, max cycles a grant may be held before forced release (used only with the timeout feature; legal range 2..255).
- CNT_W, 8, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- REQ  input  4  request per requester; REQ[i] held high until served.
- DONE  input  1  owner signals last cycle of use; sampled only while GNT_VALID=1.
- GNT  output  4  registered one-hot grant.
- GNT_IDX  output  2  binary encoding of GNT (0001->0, 0010->1, 0100->2, 1000->3).
- GNT_VALID  output  1  high while any grant is active.
- TIMEOUT  output  1  one-cycle pulse on forced release; constant 0 when the feature is compiled out.

Behaviour:
- Reset (rst_n=0 at clk edge): GNT=0, GNT_IDX=0, GNT_VALID=0, TIMEOUT=0, ptr=0, hold counter=0, state=IDLE. Applies mid-grant too; grant is dropped on that edge.
- States: IDLE, GRANT, GAP.
- IDLE: each cycle, scan REQ starting at ptr, then ptr+1, ptr+2, ptr+3 (mod 4).
  - If any bit is set, the first hit wins.
  - Next edge: GNT=onehot(win), GNT_IDX=win, GNT_VALID=1, state=GRANT.
  - Latency is 1 cycle from REQ sampled high to GNT high.
  - REQ=0 keeps the block in IDLE.
- GRANT: hold GNT/GNT_IDX stable. Release condition is DONE=1, or REQ[GNT_IDX]=0, or timeout.
  - On release, next edge: GNT=0, GNT_VALID=0, GNT_IDX holds its last value, ptr=GNT_IDX+1 (mod 4, 3 wraps to 0), state=GAP.
  - Requests from other lines during GRANT are ignored; no preemption.
- GAP: exactly one dead cycle with GNT=0.
  - Arbitration is evaluated in GAP exactly as in IDLE, using the updated ptr.
  - Next state is GRANT if any REQ is set, else IDLE.
  - Back-to-back grants are therefore separated by exactly one cycle with GNT_VALID=0.
- Simultaneous events:
  - DONE together with REQ drop: a single release.
  - DONE in IDLE or GAP: ignored.
  - Winner's REQ set and DONE=1 on the first GRANT cycle: grant lasts one cycle.
- Invariants: GNT is always one-hot or zero, and GNT_IDX always equals encode(GNT) when GNT_VALID=1.

Optional Feature:
- Macro: RR_GRANT_TIMEOUT_EN.
- Defined:
  - The hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When count==MAX_HOLD-1 and no other release is present, a forced release occurs with the same transition as DONE, and TIMEOUT=1 for the cycle the grant drops.
  - ptr advances normally, so the timed-out requester loses priority.
- Not defined: no counter logic; TIMEOUT tied 0; grants are unbounded.

Decomposition:
- Package rr_grant_pkg holds:
  - state typedef (IDLE, GRANT, GAP);
  - constants N_REQ=4 and IDX_W=2;
  - a function onehot_to_idx matching the 4-to-2 encoder mapping.
- One sub-module, rr_pick: combinational rotating priority picker.
  - Inputs REQ[3:0], ptr[1:0].
  - Outputs win_idx[1:0], any_req.
  - Reused in IDLE and GAP.

Test Plan:
- Reset, then REQ=4'b0100 -> one cycle later GNT=0100, GNT_IDX=2, GNT_VALID=1. Pulse DONE -> next cycle GNT=0; ptr=3.
- REQ=4'b1111 held, DONE pulsed on each grant's 2nd cycle -> grant order idx 0,1,2,3,0 with exactly one GNT=0 cycle between grants.
- ptr=3 (after serving idx 2), REQ=4'b0011 -> winner idx 0 (wrap), then idx 1.
- During GRANT to idx 1, assert REQ[0] and deassert REQ[1] in the same cycle as DONE=1 -> single release, GAP, then grant idx 0; no glitch on GNT.
- Assert rst_n=0 mid-grant -> next edge all outputs 0 and ptr=0. After release with REQ=4'b1000 -> GNT=1000, GNT_IDX=3.
- With RR_GRANT_TIMEOUT_EN and MAX_HOLD=16: hold REQ=4'b0001 with no DONE -> GNT drops after exactly 16 grant cycles and TIMEOUT pulses once. Without the macro -> grant held indefinitely and TIMEOUT stays 0.

Source files
------------

// File: rtl/rr_grant_pkg.sv
// Purpose : shared types and helpers for the round-robin grant scheduler.
// Latency : n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: state_t (IDLE/GRANT/GAP), N_REQ, IDX_W, onehot_to_idx (4-to-2 encoder mapping).
package rr_grant_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Same mapping as the 4-to-2 encoder feeding the shared channel select.
  // Non-one-hot input encodes to 0; the scheduler never produces one.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    case (oh)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Purpose : combinational rotating-priority picker; scans REQ from ptr upward, mod 4.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to act on win_idx/any_req.
// Ports   : REQ[3:0] requests, ptr[1:0] highest-priority line, win_idx[1:0] first hit, any_req.
module rr_pick
  import rr_grant_pkg::*;
(
  input  logic [N_REQ-1:0] REQ,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win_idx,
  output logic             any_req
);

  logic [IDX_W-1:0] cand;

  // Walk from lowest priority (ptr+3) to highest (ptr) so the last hit
  // written, i.e. the one closest to ptr, is the winner.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    any_req = |REQ;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (REQ[cand]) begin
        win_idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Purpose : round-robin owner of the shared 4-to-2 channel; registered one-hot grant + index.
// Latency : 1 cycle REQ->GNT; release drops GNT next edge, then one GAP cycle before any regrant.
// Backpressure: grant held until DONE, owner REQ drop, or (RR_GRANT_TIMEOUT_EN) MAX_HOLD cycles.
// Ports   : clk, rst_n (sync, active-low), REQ[3:0], DONE -> GNT[3:0], GNT_IDX[1:0], GNT_VALID, TIMEOUT.
// Config  : define RR_GRANT_TIMEOUT_EN to enable forced release and the TIMEOUT pulse.
module rr_grant_scheduler
  import rr_grant_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] REQ,
  input  logic             DONE,
  output logic [N_REQ-1:0] GNT,
  output logic [IDX_W-1:0] GNT_IDX,
  output logic             GNT_VALID,
  output logic             TIMEOUT
);

  // Reject configurations where the hold counter could not reach MAX_HOLD-1.
  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("rr_grant_scheduler: illegal MAX_HOLD/CNT_W combination");
  end

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win_idx;
  logic             any_req;
  logic [N_REQ-1:0] win_oh;
  logic             owner_rel;
  logic             timeout_fire;
  logic             release_now;

  rr_pick u_pick (
    .REQ     (REQ),
    .ptr     (ptr),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  assign win_oh = N_REQ'(1) << win_idx;

  // Owner-driven release: explicit DONE or the owner dropping its request.
  assign owner_rel   = (state == GRANT) && (DONE || !REQ[GNT_IDX]);
  assign release_now = owner_rel || timeout_fire;

`ifdef RR_GRANT_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;

  // Counter sits at 0 outside GRANT, so it is 0 on the first GRANT cycle
  // and equals MAX_HOLD-1 on the MAX_HOLD-th one.
  assign timeout_fire = (state == GRANT) && !owner_rel &&
                        (hold_cnt == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_fire;
      if (state == GRANT && !release_now) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end else begin
        hold_cnt <= '0;
      end
    end
  end

  assign TIMEOUT = timeout_q;
`else
  assign timeout_fire = 1'b0;
  assign TIMEOUT      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      GNT       <= '0;
      GNT_IDX   <= '0;
      GNT_VALID <= 1'b0;
    end else begin
      case (state)
        // IDLE and GAP arbitrate identically; GAP only exists to force
        // one GNT=0 cycle between consecutive owners.
        IDLE, GAP: begin
          if (any_req) begin
            GNT       <= win_oh;
            GNT_IDX   <= onehot_to_idx(win_oh);
            GNT_VALID <= 1'b1;
            state     <= GRANT;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          // GNT_IDX keeps its last value across the release.
          if (release_now) begin
            GNT       <= '0;
            GNT_VALID <= 1'b0;
            ptr       <= GNT_IDX + IDX_W'(1);
            state     <= GAP;
          end
        end
        default: begin
          GNT       <= '0;
          GNT_VALID <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
module tb_rr_grant_scheduler;
  import rr_grant_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks;
  int errors;

  rr_grant_scheduler #(.MAX_HOLD(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .REQ       (req),
    .DONE      (done),
    .GNT       (gnt),
    .GNT_IDX   (gnt_idx),
    .GNT_VALID (gnt_valid),
    .TIMEOUT   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_idx,
                         input logic e_vld, input logic e_to);
    chk({tag, ".gnt"}, {4'h0, gnt}, {4'h0, e_gnt});
    chk({tag, ".idx"}, {6'h0, gnt_idx}, {6'h0, e_idx});
    chk({tag, ".vld"}, {7'h0, gnt_valid}, {7'h0, e_vld});
    chk({tag, ".timeout"}, {7'h0, timeout}, {7'h0, e_to});
    if (gnt_valid === 1'b1) begin
      chk({tag, ".enc"}, {6'h0, onehot_to_idx(gnt)}, {6'h0, gnt_idx});
    end
  endtask

  initial begin
    int order [5];
    logic [3:0] oh;
    order = '{0, 1, 2, 3, 0};
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;

    // Reset state.
    tick();
    tick();
    chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single request on line 2, released by DONE; ptr becomes 3.
    req = 4'b0100;
    tick();
    chk_out("t1_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    done = 1'b1;
    req  = 4'b0000;
    tick();
    chk_out("t1_release", 4'b0000, 2'd2, 1'b0, 1'b0);
    done = 1'b0;
    tick();
    chk_out("t1_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

    // ptr=3, REQ=0011: wrap to idx 0, then idx 1.
    req = 4'b0011;
    tick();
    chk_out("t3_wrap", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b1;
    req  = 4'b0010;
    tick();
    chk_out("t3_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0;
    tick();
    chk_out("t3_next", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick();
    chk_out("t3_hold", 4'b0010, 2'd1, 1'b1, 1'b0);

    // DONE together with owner REQ drop and a new REQ[0]: single release.
    req  = 4'b0001;
    done = 1'b1;
    tick();
    chk_out("t4_release", 4'b0000, 2'd1, 1'b0, 1'b0);
    done = 1'b0;
    tick();
    chk_out("t4_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Reset mid-grant drops everything; then REQ=1000 wins from ptr=0.
    rst_n = 1'b0;
    req   = 4'b1000;
    tick();
    chk_out("t5_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("t5_after", 4'b1000, 2'd3, 1'b1, 1'b0);
    done = 1'b1;
    req  = 4'b0000;
    tick();
    chk_out("t5_release", 4'b0000, 2'd3, 1'b0, 1'b0);
    done = 1'b0;
    tick();

    // All requesting, DONE on each grant's 2nd cycle: 0,1,2,3,0 with one gap.
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << order[k];
      tick();
      chk_out($sformatf("t2_g%0d_c1", k), oh, 2'(order[k]), 1'b1, 1'b0);
      tick();
      chk_out($sformatf("t2_g%0d_c2", k), oh, 2'(order[k]), 1'b1, 1'b0);
      done = 1'b1;
      tick();
      chk_out($sformatf("t2_g%0d_gap", k), 4'b0000, 2'(order[k]), 1'b0, 1'b0);
      done = 1'b0;
    end

    // Held request with no DONE (ptr=1, only line 0 requesting).
    req = 4'b0001;
    tick();
    chk_out("t6_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef RR_GRANT_TIMEOUT_EN
    for (int c = 2; c <= 16; c++) begin
      tick();
      chk_out($sformatf("t6_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick();
    chk_out("t6_timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    chk_out("t6_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
`else
    for (int c = 2; c <= 40; c++) begin
      tick();
      chk_out($sformatf("t6_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
